// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   UART transmitter fed by a circular transmit FIFO. Characters pushed with
//   tx_trig are queued and sent as frames of
//   start + DATA_BITS (LSB first) + optional parity + STOP_BITS stop bits,
//   each bit lasting CLK_HZ/BAUD clock cycles. Queued frames abut with no idle gap.
//
// Parameters
//   CLK_HZ, BAUD : bit period BAUD_CNT = CLK_HZ / BAUD (must be >= 2)
//   DATA_BITS    : 5..8
//   PARITY       : 0 none, 1 odd, 2 even
//   STOP_BITS    : 1 or 2
//   FIFO_DEPTH   : power of 2, >= 2
//
// Ports
//   sclk        : system clock, rising edge
//   s_rst_n     : synchronous active-low reset (flushes FIFO, aborts frame)
//   tx_trig     : push strobe, one character per high cycle
//   tx_data     : character to push
//   rs232_tx    : serial line, idles high
//   fifo_full   : FIFO holds FIFO_DEPTH entries
//   fifo_empty  : FIFO holds no entries
//   fifo_level  : current FIFO occupancy
//   busy        : frame in progress on the line
//   drop_flag   : one-cycle pulse after a push that hit a full FIFO
module uart_tx_fifo #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          sclk,
  input  logic                          s_rst_n,
  input  logic                          tx_trig,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          rs232_tx,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          drop_flag
);

  localparam int BAUD_CNT = CLK_HZ / BAUD;
  localparam int CW       = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int LW       = AW + 1;

  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CNT - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [LW-1:0] LEVEL_MAX = LW'(FIFO_DEPTH);
  localparam logic          HAS_PAR   = (PARITY != 0);
  // Odd parity is the inverse of the data XOR.
  localparam logic          PAR_INV   = (PARITY == 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // ---------------------------------------------------------------------------
  // Transmit FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LW-1:0]        level_n;
  logic [DATA_BITS-1:0] head;
  logic                 push_ok;
  logic                 pop;

  // Acceptance uses the registered full flag, so a push into a full FIFO is
  // dropped even when a pop frees a slot in the same cycle.
  assign push_ok = tx_trig && !fifo_full;
  assign head    = mem[rd_ptr];

  always_comb begin
    level_n = fifo_level;
    if (push_ok && !pop) begin
      level_n = fifo_level + 1'b1;
    end else if (!push_ok && pop) begin
      level_n = fifo_level - 1'b1;
    end
  end

  always_ff @(posedge sclk) begin
    if (push_ok) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
      drop_flag  <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      fifo_level <= level_n;
      fifo_full  <= (level_n == LEVEL_MAX);
      fifo_empty <= (level_n == '0);
      drop_flag  <= tx_trig && fifo_full;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame state machine
  // ---------------------------------------------------------------------------
  logic [2:0]           state;
  logic [2:0]           state_n;
  logic [CW-1:0]        baud_cnt;
  logic [CW-1:0]        baud_n;
  logic [2:0]           bit_cnt;
  logic [2:0]           bit_n;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_n;
  logic                 par_bit;
  logic                 par_n;
  logic                 tx_n;
  logic                 bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_reg;
    par_n   = par_bit;
    pop     = 1'b0;

    if (state != S_IDLE) begin
      baud_n = bit_end ? '0 : baud_cnt + 1'b1;
    end

    case (state)
      S_IDLE: begin
        baud_n = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = head;
          par_n   = (^head) ^ PAR_INV;
          bit_n   = '0;
          state_n = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_n   = '0;
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        // Shift on each bit boundary so shift_reg[0] is always the bit on the line.
        if (bit_end) begin
          shift_n = shift_reg >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_n   = '0;
            state_n = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          bit_n   = '0;
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_cnt == STOP_LAST) begin
            // Back-to-back: load the next character without passing through IDLE.
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_n = head;
              par_n   = (^head) ^ PAR_INV;
              bit_n   = '0;
              state_n = S_START;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        baud_n  = '0;
        bit_n   = '0;
      end
    endcase
  end

  // Line level is derived from the next-state values so rs232_tx and busy
  // are registered yet change on the same edge as the state.
  always_comb begin
    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shift_n[0];
      S_PARITY: tx_n = par_n;
      default:  tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      rs232_tx  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_cnt   <= bit_n;
      shift_reg <= shift_n;
      par_bit   <= par_n;
      rs232_tx  <= tx_n;
      busy      <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Four transmitter instances (BAUD_CNT = 10):
//     u0: 8N1, FIFO_DEPTH 4   u1: 8E1   u2: 8O1   u3: 7N2
//   Stimulus pushes the expected frame into a per-instance queue; a monitor per
//   instance decodes each frame from the line and compares against the queue.
module tb_uart_tx_fifo;

  logic sclk = 1'b0;
  always #5 sclk = ~sclk;

  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  logic       rst_n [4];
  logic       trig  [4];
  logic [7:0] din   [4];
  logic       line  [4];
  logic       full  [4];
  logic       empty [4];
  logic       busy  [4];
  logic       drop  [4];
  logic [2:0] lvl0;
  logic [4:0] lvl1;
  logic [4:0] lvl2;
  logic [4:0] lvl3;

  localparam int DB [4] = '{8, 8, 8, 7};
  localparam int PB [4] = '{0, 2, 1, 0};
  localparam int SB [4] = '{1, 1, 1, 2};

  uart_tx_fifo #(.CLK_HZ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .sclk(sclk), .s_rst_n(rst_n[0]), .tx_trig(trig[0]), .tx_data(din[0]),
    .rs232_tx(line[0]), .fifo_full(full[0]), .fifo_empty(empty[0]),
    .fifo_level(lvl0), .busy(busy[0]), .drop_flag(drop[0]));

  uart_tx_fifo #(.CLK_HZ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) u1 (
    .sclk(sclk), .s_rst_n(rst_n[1]), .tx_trig(trig[1]), .tx_data(din[1]),
    .rs232_tx(line[1]), .fifo_full(full[1]), .fifo_empty(empty[1]),
    .fifo_level(lvl1), .busy(busy[1]), .drop_flag(drop[1]));

  uart_tx_fifo #(.CLK_HZ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(1),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) u2 (
    .sclk(sclk), .s_rst_n(rst_n[2]), .tx_trig(trig[2]), .tx_data(din[2]),
    .rs232_tx(line[2]), .fifo_full(full[2]), .fifo_empty(empty[2]),
    .fifo_level(lvl2), .busy(busy[2]), .drop_flag(drop[2]));

  uart_tx_fifo #(.CLK_HZ(1000), .BAUD(100), .DATA_BITS(7), .PARITY(0),
                 .STOP_BITS(2), .FIFO_DEPTH(16)) u3 (
    .sclk(sclk), .s_rst_n(rst_n[3]), .tx_trig(trig[3]), .tx_data(din[3][6:0]),
    .rs232_tx(line[3]), .fifo_full(full[3]), .fifo_empty(empty[3]),
    .fifo_level(lvl3), .busy(busy[3]), .drop_flag(drop[3]));

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         start_cyc;  // -1: no latency check
    bit         abut;       // must start exactly where the previous frame ended
  } frame_t;

  frame_t sbq [4][$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int get_level(input int i);
    case (i)
      0:       return int'(lvl0);
      1:       return int'(lvl1);
      2:       return int'(lvl2);
      default: return int'(lvl3);
    endcase
  endfunction

  task automatic expect_frame(input int i, input logic [7:0] d, input logic p,
                              input int sc, input bit ab);
    frame_t e;
    e.data = d; e.par = p; e.start_cyc = sc; e.abut = ab;
    sbq[i].push_back(e);
  endtask

  // Monitor: samples #1 after each rising edge; decodes one frame per start edge.
  task automatic monitor(input int i);
    logic       prev;
    logic       v [12];
    logic       stab;
    logic       aborted;
    logic [7:0] d;
    int         s;
    int         nb;
    int         prev_end;
    frame_t     e;
    prev     = 1'b1;
    prev_end = -1;
    nb       = 1 + DB[i] + ((PB[i] != 0) ? 1 : 0) + SB[i];
    forever begin
      @(posedge sclk); #1;
      if (prev && !line[i] && rst_n[i]) begin
        s       = cyc;
        stab    = 1'b1;
        aborted = 1'b0;
        for (int b = 0; b < nb; b++) begin
          for (int c = 0; c < 10; c++) begin
            if (b != 0 || c != 0) begin
              @(posedge sclk); #1;
            end
            if (!rst_n[i]) begin
              aborted = 1'b1;
              break;
            end
            if (c == 0) v[b] = line[i];
            else if (line[i] != v[b]) stab = 1'b0;
          end
          if (aborted) break;
        end
        if (aborted) begin
          prev_end = -1;
        end else if (sbq[i].size() == 0) begin
          check($sformatf("u%0d_unexpected_frame", i), 1, 0);
          prev_end = s + 10 * nb;
        end else begin
          e = sbq[i].pop_front();
          d = '0;
          for (int j = 0; j < DB[i]; j++) d[j] = v[1 + j];
          check($sformatf("u%0d_start_bit", i), int'(v[0]), 0);
          check($sformatf("u%0d_data", i), int'(d), int'(e.data));
          if (PB[i] != 0)
            check($sformatf("u%0d_parity", i), int'(v[1 + DB[i]]), int'(e.par));
          for (int j = 0; j < SB[i]; j++)
            check($sformatf("u%0d_stop%0d", i, j), int'(v[nb - SB[i] + j]), 1);
          check($sformatf("u%0d_bit_width", i), int'(stab), 1);
          if (e.start_cyc >= 0)
            check($sformatf("u%0d_latency", i), s, e.start_cyc);
          if (e.abut)
            check($sformatf("u%0d_gap", i), s, prev_end);
          prev_end = s + 10 * nb;
        end
        prev = line[i];
      end else begin
        prev = line[i];
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);
  initial monitor(3);

  task automatic wait_idle(input int i);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (sbq[i].size() == 0 && !busy[i] && empty[i]) begin
        ok = 1'b1;
        break;
      end
      @(negedge sclk);
    end
    check($sformatf("u%0d_drain", i), int'(ok), 1);
  endtask

  // Push one character into an idle instance, check latency, levels and busy length.
  task automatic single(input int i, input logic [7:0] d, input logic p, input int flen);
    int n;
    @(negedge sclk);
    trig[i] = 1'b1; din[i] = d;
    expect_frame(i, d, p, cyc + 2, 1'b0);
    @(negedge sclk);
    trig[i] = 1'b0;
    check($sformatf("u%0d_empty_after_push", i), int'(empty[i]), 0);
    check($sformatf("u%0d_level_after_push", i), get_level(i), 1);
    @(negedge sclk);
    check($sformatf("u%0d_level_after_pop", i), get_level(i), 0);
    check($sformatf("u%0d_busy_rise", i), int'(busy[i]), 1);
    check($sformatf("u%0d_line_start", i), int'(line[i]), 0);
    n = 1;
    for (int t = 0; t < 300 && busy[i]; t++) begin
      @(negedge sclk);
      if (busy[i]) n++;
    end
    check($sformatf("u%0d_busy_len", i), n, flen);
    check($sformatf("u%0d_line_idle", i), int'(line[i]), 1);
    wait_idle(i);
  endtask

  initial begin
    int k;
    int quiet;
    for (int i = 0; i < 4; i++) begin
      rst_n[i] = 1'b0; trig[i] = 1'b0; din[i] = '0;
    end
    repeat (3) @(negedge sclk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("u%0d_rst_tx", i),    int'(line[i]),  1);
      check($sformatf("u%0d_rst_busy", i),  int'(busy[i]),  0);
      check($sformatf("u%0d_rst_empty", i), int'(empty[i]), 1);
      check($sformatf("u%0d_rst_full", i),  int'(full[i]),  0);
      check($sformatf("u%0d_rst_drop", i),  int'(drop[i]),  0);
      check($sformatf("u%0d_rst_level", i), get_level(i),   0);
      rst_n[i] = 1'b1;
    end
    repeat (2) @(negedge sclk);

    // Single byte and format/parity variants
    single(0, 8'h55, 1'b0, 100);
    single(0, 8'hC3, 1'b0, 100);
    single(1, 8'h07, 1'b1, 110);
    single(1, 8'hA5, 1'b0, 110);
    single(2, 8'h07, 1'b0, 110);
    single(2, 8'hA5, 1'b1, 110);
    single(3, 8'h7F, 1'b0, 100);
    single(3, 8'h05, 1'b0, 100);

    // Overflow: fill the 4-deep FIFO while a frame is on the line
    @(negedge sclk);
    trig[0] = 1'b1; din[0] = 8'h3C;
    expect_frame(0, 8'h3C, 1'b0, cyc + 2, 1'b0);
    @(negedge sclk);
    trig[0] = 1'b0;
    repeat (20) @(negedge sclk);
    trig[0] = 1'b1; din[0] = 8'hA1; expect_frame(0, 8'hA1, 1'b0, -1, 1'b1);
    @(negedge sclk); din[0] = 8'hA2; expect_frame(0, 8'hA2, 1'b0, -1, 1'b1);
    @(negedge sclk); din[0] = 8'hA3; expect_frame(0, 8'hA3, 1'b0, -1, 1'b1);
    @(negedge sclk); din[0] = 8'hA4; expect_frame(0, 8'hA4, 1'b0, -1, 1'b1);
    @(negedge sclk);
    check("ovf_full", int'(full[0]), 1);
    check("ovf_level4", get_level(0), 4);
    check("ovf_no_drop_yet", int'(drop[0]), 0);
    din[0] = 8'hA5;
    @(negedge sclk);
    trig[0] = 1'b0;
    check("ovf_drop_pulse", int'(drop[0]), 1);
    check("ovf_level_held", get_level(0), 4);
    check("ovf_full_held", int'(full[0]), 1);
    @(negedge sclk);
    check("ovf_drop_end", int'(drop[0]), 0);
    wait_idle(0);
    check("ovf_level_final", get_level(0), 0);
    check("ovf_full_final", int'(full[0]), 0);

    // Simultaneous push and STOP->START pop at level 2
    @(negedge sclk);
    trig[0] = 1'b1; din[0] = 8'h11; k = cyc + 1;
    expect_frame(0, 8'h11, 1'b0, k + 1, 1'b0);
    @(negedge sclk); din[0] = 8'h22; expect_frame(0, 8'h22, 1'b0, -1, 1'b1);
    @(negedge sclk); din[0] = 8'h33; expect_frame(0, 8'h33, 1'b0, -1, 1'b1);
    @(negedge sclk); trig[0] = 1'b0;
    check("pp_level_before", get_level(0), 2);
    for (int t = 0; t < 200 && cyc < k + 100; t++) @(negedge sclk);
    check("pp_level_at_stop", get_level(0), 2);
    trig[0] = 1'b1; din[0] = 8'h44; expect_frame(0, 8'h44, 1'b0, -1, 1'b1);
    @(negedge sclk);
    trig[0] = 1'b0;
    check("pp_level_after", get_level(0), 2);
    wait_idle(0);

    // Reset during DATA with three characters queued
    @(negedge sclk);
    trig[0] = 1'b1; din[0] = 8'h5A;
    @(negedge sclk); din[0] = 8'h5B;
    @(negedge sclk); din[0] = 8'h5C;
    @(negedge sclk); din[0] = 8'h5D;
    @(negedge sclk); trig[0] = 1'b0;
    check("rst_mid_level3", get_level(0), 3);
    repeat (30) @(negedge sclk);
    check("rst_mid_busy", int'(busy[0]), 1);
    rst_n[0] = 1'b0;
    @(negedge sclk);
    check("rst_mid_tx", int'(line[0]), 1);
    check("rst_mid_busy0", int'(busy[0]), 0);
    check("rst_mid_level0", get_level(0), 0);
    check("rst_mid_empty", int'(empty[0]), 1);
    check("rst_mid_full", int'(full[0]), 0);
    rst_n[0] = 1'b1;
    quiet = 0;
    repeat (200) begin
      @(negedge sclk);
      if (!line[0] || busy[0]) quiet++;
    end
    check("rst_mid_quiet", quiet, 0);
    single(0, 8'h81, 1'b0, 100);

    for (int i = 0; i < 4; i++) wait_idle(i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with a built-in transmit FIFO. It replaces the single-byte, trigger-driven transmitter in the echo/loopback path. Upstream logic (e.g. the receiver's `po_flag`/`rx_data`) can push bursts of characters without waiting for each frame to finish. Character length, parity, stop bits, baud rate and buffer depth are all parameters, and the block runs in the 50 MHz system clock domain.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate. Bit period `BAUD_CNT = CLK_HZ / BAUD`, integer divide with truncation; 5208 at the defaults. `BAUD_CNT` must be at least 2.
- `DATA_BITS`, default 8: character length, legal values 5 to 8.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: legal values 1 or 2.
- `FIFO_DEPTH`, default 16: entries; must be a power of 2 and at least 2.
- `sclk` input, 1 bit: system clock; all logic runs on its rising edge.
- `s_rst_n` input, 1 bit: synchronous, active-low reset.
- `tx_trig` input, 1 bit: push strobe; each cycle it is high pushes one character.
- `tx_data` input, `DATA_BITS` wide: character pushed when `tx_trig` is high.
- `rs232_tx` output, 1 bit: serial line; idles high.
- `fifo_full` output, 1 bit: FIFO holds `FIFO_DEPTH` entries.
- `fifo_empty` output, 1 bit: FIFO holds no entries.
- `fifo_level` output, `$clog2(FIFO_DEPTH)+1` wide: current occupancy.
- `busy` output, 1 bit: a frame is in progress on the line.
- `drop_flag` output, 1 bit: one-cycle pulse when a push is discarded.

## Operation
- **FIFO**
  - Circular buffer with read and write pointers, plus a level counter.
  - A push with `fifo_full` = 1 is discarded. `drop_flag` pulses on the next cycle, and FIFO contents are unchanged. This applies even if a pop happens in the same cycle.
  - A push and a pop in the same cycle with the FIFO neither empty nor full: level unchanged, data order preserved.
  - `fifo_full` and `fifo_empty` are registered and consistent with `fifo_level` on every cycle.
- **State machine:** IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** `rs232_tx` = 1. If the FIFO is not empty, pop the head into the shift register, clear the bit counter, and go to START.
  - **START:** `rs232_tx` = 0 for `BAUD_CNT` cycles, then go to DATA.
  - **DATA:** send `DATA_BITS` bits LSB first, each held for `BAUD_CNT` cycles. Then go to PARITY if `PARITY` ≠ 0, otherwise to STOP.
  - **PARITY:** one bit for `BAUD_CNT` cycles.
    - Even parity: XOR of the data bits.
    - Odd parity: inverse of that XOR.
  - **STOP:** `rs232_tx` = 1 for `STOP_BITS*BAUD_CNT` cycles. At the final cycle:
    - if the FIFO is not empty, pop and go straight to START, with no idle gap;
    - otherwise go to IDLE.
- **Baud counter:** counts 0 to `BAUD_CNT-1`. It wraps to 0 on every bit boundary and is held at 0 in IDLE.
- **`busy`:** high in every state except IDLE.
- **Reset (`s_rst_n` low at a rising edge)**
  - Flushes the FIFO and aborts any frame in progress.
  - After that edge: `rs232_tx` = 1, `busy` = 0, `fifo_empty` = 1, `fifo_full` = 0, `fifo_level` = 0, `drop_flag` = 0, state IDLE.
  - A truncated frame mid-reset is acceptable.
- **Width rules:** `fifo_level` saturates by construction at `FIFO_DEPTH`. Pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap naturally.

## Timing
- Push-to-line latency: with `tx_trig` sampled high at edge k into an empty FIFO while IDLE, `fifo_empty` falls after edge k. The pop occurs at edge k+1, and `rs232_tx` goes low after edge k+1.
- Frame length is exactly `(1 + DATA_BITS + (PARITY≠0) + STOP_BITS) * BAUD_CNT` cycles. Consecutive queued frames abut with no extra idle cycles.
- `drop_flag` is high for exactly one cycle, the cycle after the rejected push edge.
- `busy` rises with the start bit and falls in the same cycle that `rs232_tx` returns to idle in IDLE.
- Outputs are registered, with no combinational path from `tx_trig` to any output.

## Test plan
- **Single byte:** `CLK_HZ`=1000, `BAUD`=100 (so `BAUD_CNT`=10), 8N1. Push 0x55 → start edge 2 cycles after the push. The line reads 0,1,0,1,0,1,0,1,0,1, each bit held 10 cycles, frame 100 cycles. `busy` is high for exactly 100 cycles.
- **Parity:** `PARITY`=2, push 0x07 → parity bit 1. `PARITY`=1, push 0x07 → parity bit 0. Frame is 110 cycles.
- **Overflow:** `FIFO_DEPTH`=4. Push 5 characters on consecutive cycles (0xA1 to 0xA5) → `fifo_full`=1 and `drop_flag` pulses once, for 0xA5. Exactly 0xA1 to 0xA4 are sent as 4 back-to-back frames with no gap, and `fifo_level` returns to 0.
- **Simultaneous push/pop:** with level 2, push in the same cycle the STOP→START pop occurs → level stays 2 and order is preserved.
- **Format variant:** `DATA_BITS`=7, `STOP_BITS`=2. Push 0x7F → 7 data ones, then 20 cycles high, frame 100 cycles.
- **Reset mid-frame:** assert `s_rst_n` low during DATA with 3 characters queued → after the reset edge, `rs232_tx`=1, `busy`=0, `fifo_level`=0. No further frames are sent until a new push.
